// File: rtl/ext_domain_pwr_seq_pkg.sv
// Shared types for the external power-domain sequencer.
// State encodings are software-visible through pwr_state_o.
package ext_domain_pwr_seq_pkg;

  localparam int unsigned PWR_STATE_W = 4;

  typedef enum logic [PWR_STATE_W-1:0] {
    S_INIT    = 4'd0,
    S_ON      = 4'd1,
    S_CLK_OFF = 4'd2,
    S_ISO_ON  = 4'd3,
    S_RST_ON  = 4'd4,
    S_SW_OFF  = 4'd5,
    S_OFF     = 4'd6,
    S_SW_ON   = 4'd7,
    S_CLK_ON  = 4'd8,
    S_RST_REL = 4'd9,
    S_ISO_REL = 4'd10,
    S_ERROR   = 4'd11
  } pwr_state_e;

endpackage

// File: rtl/ext_domain_pwr_ack_sync.sv
// Multi-flop synchroniser for the asynchronous switch-cell acknowledge.
// Reset value is a parameter so the chain can start at a known level.
module ext_domain_pwr_ack_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/ext_domain_pwr_seq.sv
// Power-gating sequencer for one external domain: orders clock, isolation,
// reset and switch pins, and waits for the switch ack under a timeout.
module ext_domain_pwr_seq
  import ext_domain_pwr_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned ISO_CYCLES  = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  input  logic                   req_on_i,
  output logic                   req_ready_o,
  input  logic                   ret_en_i,
  input  logic                   err_clr_i,
  output logic                   done_o,
  output logic                   busy_o,
  output logic                   err_o,
  output logic [PWR_STATE_W-1:0] pwr_state_o,
  output logic                   switch_no,
  input  logic                   switch_ack_ni,
  output logic                   iso_no,
  output logic                   rst_no,
  output logic                   clk_en_no,
  output logic                   ret_no
);

  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYCLES - 1);

  pwr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             boot_q, boot_d;
  logic             sw_q, sw_d;
  logic             iso_q, iso_d;
  logic             rst_q, rst_d;
  logic             clk_q, clk_d;
  logic             ret_q, ret_d;
  logic             rdy_q, rdy_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ack_s;
  logic             req_acc;

  ext_domain_pwr_ack_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (switch_ack_ni),
    .q_o    (ack_s)
  );

  assign req_acc = req_valid_i & rdy_q;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    boot_d  = boot_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_INIT:    if (cnt_q == RST_LAST) state_d = S_ISO_REL;
      S_ON: begin
        if (req_acc) begin
          if (req_on_i) done_d = 1'b1;
          else state_d = S_CLK_OFF;
        end
      end
      S_CLK_OFF: state_d = S_ISO_ON;
      S_ISO_ON:  if (cnt_q == ISO_LAST) state_d = S_RST_ON;
      S_RST_ON:  state_d = S_SW_OFF;
      S_SW_OFF: begin
        if (ack_s) begin
          state_d = S_OFF;
          done_d  = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_ERROR;
          dir_d   = 1'b0;
        end
      end
      S_OFF: begin
        if (req_acc) begin
          if (!req_on_i) done_d = 1'b1;
          else state_d = S_SW_ON;
        end
      end
      S_SW_ON: begin
        if (!ack_s) begin
          state_d = S_CLK_ON;
        end else if (cnt_q == ACK_LAST) begin
          state_d = S_ERROR;
          dir_d   = 1'b1;
        end
      end
      S_CLK_ON:  if (cnt_q == RST_LAST) state_d = S_RST_REL;
      S_RST_REL: if (cnt_q == ISO_LAST) state_d = S_ISO_REL;
      S_ISO_REL: begin
        state_d = S_ON;
        done_d  = ~boot_q;
        boot_d  = 1'b0;
      end
      S_ERROR: begin
        if (err_clr_i) state_d = dir_q ? S_SW_ON : S_SW_OFF;
      end
      default:   state_d = S_INIT;
    endcase
  end

  // Pins change only on state entry, so ERROR naturally freezes them.
  always_comb begin
    sw_d  = sw_q;
    iso_d = iso_q;
    rst_d = rst_q;
    clk_d = clk_q;
    ret_d = ret_q;
    if (state_d != state_q) begin
      unique case (state_d)
        S_CLK_OFF: clk_d = 1'b1;
        S_ISO_ON:  iso_d = 1'b0;
        S_RST_ON:  rst_d = 1'b0;
        S_SW_OFF:  sw_d  = 1'b1;
        S_SW_ON: begin
          sw_d  = 1'b0;
          ret_d = 1'b1;
        end
        S_CLK_ON:  clk_d = 1'b0;
        S_RST_REL: rst_d = 1'b1;
        S_ISO_REL: begin
          iso_d = 1'b1;
          rst_d = 1'b1;
        end
        default: ;
      endcase
    end
    if (state_d == S_OFF) ret_d = ~ret_en_i;
  end

  always_comb begin
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q inside {S_ON, S_OFF, S_ERROR}) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    rdy_d  = state_d inside {S_ON, S_OFF};
    busy_d = !(state_d inside {S_ON, S_OFF, S_ERROR});
    err_d  = state_d == S_ERROR;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      boot_q  <= 1'b1;
      sw_q    <= 1'b0;
      iso_q   <= 1'b0;
      rst_q   <= 1'b0;
      clk_q   <= 1'b0;
      ret_q   <= 1'b1;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      boot_q  <= boot_d;
      sw_q    <= sw_d;
      iso_q   <= iso_d;
      rst_q   <= rst_d;
      clk_q   <= clk_d;
      ret_q   <= ret_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pwr_state_o = state_q;
  assign switch_no   = sw_q;
  assign iso_no      = iso_q;
  assign rst_no      = rst_q;
  assign clk_en_no   = clk_q;
  assign ret_no      = ret_q;
  assign req_ready_o = rdy_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_ext_domain_pwr_seq.sv
// Directed vector bench for ext_domain_pwr_seq.
// Pins are packed {switch,iso,rst,clk_en,ret}; flags {ready,done,busy,err}.
module tb_ext_domain_pwr_seq;
  import ext_domain_pwr_seq_pkg::*;

  typedef struct {
    logic       v;
    logic       on;
    logic       ret;
    logic       clr;
    logic       ack;
    int         n;
    logic [3:0] st;
    logic [4:0] pins;
    logic [3:0] flg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid_i = 1'b0;
  logic       req_on_i = 1'b0;
  logic       ret_en_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic       switch_ack_ni = 1'b1;
  logic       req_ready_o, done_o, busy_o, err_o;
  logic [3:0] pwr_state_o;
  logic       switch_no, iso_no, rst_no, clk_en_no, ret_no;

  int   applied = 0;
  int   miscompares = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  ext_domain_pwr_seq dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_on_i      (req_on_i),
    .req_ready_o   (req_ready_o),
    .ret_en_i      (ret_en_i),
    .err_clr_i     (err_clr_i),
    .done_o        (done_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .pwr_state_o   (pwr_state_o),
    .switch_no     (switch_no),
    .switch_ack_ni (switch_ack_ni),
    .iso_no        (iso_no),
    .rst_no        (rst_no),
    .clk_en_no     (clk_en_no),
    .ret_no        (ret_no)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, on, ret, clr, ack, input int n,
                     input logic [3:0] st, input logic [4:0] pins,
                     input logic [3:0] flg);
    vec_t t;
    t.v = v; t.on = on; t.ret = ret; t.clr = clr; t.ack = ack;
    t.n = n; t.st = st; t.pins = pins; t.flg = flg;
    vq.push_back(t);
  endtask

  task automatic check(input string name, input logic [3:0] st,
                       input logic [4:0] pins, input logic [3:0] flg);
    logic [4:0] ap;
    logic [3:0] af;
    ap = {switch_no, iso_no, rst_no, clk_en_no, ret_no};
    af = {req_ready_o, done_o, busy_o, err_o};
    applied++;
    if (pwr_state_o !== st || ap !== pins || af !== flg) begin
      miscompares++;
      $display("FAIL %s: got state=%0d pins=%b flags=%b, want state=%0d pins=%b flags=%b",
               name, pwr_state_o, ap, af, st, pins, flg);
    end
  endtask

  initial begin
    // boot: INIT 4 cycles, ISO_REL, ON without done
    add(0,0,0,0,1, 3, S_INIT,    5'b00001, 4'b0010);
    add(0,0,0,0,1, 1, S_ISO_REL, 5'b01101, 4'b0010);
    add(0,0,0,0,1, 1, S_ON,      5'b01101, 4'b1000);
    add(0,0,0,0,1, 9, S_ON,      5'b01101, 4'b1000);
    add(0,0,0,0,0, 2, S_ON,      5'b01101, 4'b1000);
    // off request, ack 15 cycles late
    add(1,0,0,0,0, 1, S_CLK_OFF, 5'b01111, 4'b0010);
    add(0,0,0,0,0, 1, S_ISO_ON,  5'b00111, 4'b0010);
    add(0,0,0,0,0, 1, S_ISO_ON,  5'b00111, 4'b0010);
    add(0,0,0,0,0, 1, S_RST_ON,  5'b00011, 4'b0010);
    add(0,0,0,0,0, 1, S_SW_OFF,  5'b10011, 4'b0010);
    add(0,0,0,0,0,14, S_SW_OFF,  5'b10011, 4'b0010);
    add(0,0,0,0,1, 2, S_SW_OFF,  5'b10011, 4'b0010);
    add(0,0,0,0,1, 1, S_OFF,     5'b10011, 4'b1100);
    add(0,0,0,0,1, 1, S_OFF,     5'b10011, 4'b1000);
    // retention, matching off request
    add(0,0,1,0,1, 1, S_OFF,     5'b10010, 4'b1000);
    add(1,0,1,0,1, 1, S_OFF,     5'b10010, 4'b1100);
    add(0,0,1,0,1, 1, S_OFF,     5'b10010, 4'b1000);
    // on request
    add(1,1,1,0,1, 1, S_SW_ON,   5'b00011, 4'b0010);
    add(0,0,1,0,1, 3, S_SW_ON,   5'b00011, 4'b0010);
    add(0,0,0,0,0, 2, S_SW_ON,   5'b00011, 4'b0010);
    add(0,0,0,0,0, 1, S_CLK_ON,  5'b00001, 4'b0010);
    add(0,0,0,0,0, 3, S_CLK_ON,  5'b00001, 4'b0010);
    add(0,0,0,0,0, 1, S_RST_REL, 5'b00101, 4'b0010);
    add(0,0,0,0,0, 1, S_RST_REL, 5'b00101, 4'b0010);
    add(0,0,0,0,0, 1, S_ISO_REL, 5'b01101, 4'b0010);
    add(0,0,0,0,0, 1, S_ON,      5'b01101, 4'b1100);
    // err_clr outside ERROR, ack glitch in ON
    add(0,0,0,1,0, 1, S_ON,      5'b01101, 4'b1000);
    add(0,0,0,0,1, 3, S_ON,      5'b01101, 4'b1000);
    add(0,0,0,0,0, 3, S_ON,      5'b01101, 4'b1000);
    // request while busy, then ack timeout
    add(1,0,0,0,0, 1, S_CLK_OFF, 5'b01111, 4'b0010);
    add(1,1,0,0,0, 1, S_ISO_ON,  5'b00111, 4'b0010);
    add(0,0,0,0,0, 2, S_RST_ON,  5'b00011, 4'b0010);
    add(0,0,0,0,0, 1, S_SW_OFF,  5'b10011, 4'b0010);
    add(0,0,0,0,0,63, S_SW_OFF,  5'b10011, 4'b0010);
    add(0,0,0,0,0, 1, S_ERROR,   5'b10011, 4'b0001);
    add(0,0,1,0,1, 5, S_ERROR,   5'b10011, 4'b0001);
    add(0,0,0,1,1, 1, S_SW_OFF,  5'b10011, 4'b0010);
    add(0,0,0,0,1, 1, S_OFF,     5'b10011, 4'b1100);
    add(1,1,0,0,1, 1, S_SW_ON,   5'b00011, 4'b0010);

    step(3);
    check("reset", S_INIT, 5'b00001, 4'b0010);
    rst_ni = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      req_valid_i   = vq[i].v;
      req_on_i      = vq[i].on;
      ret_en_i      = vq[i].ret;
      err_clr_i     = vq[i].clr;
      switch_ack_ni = vq[i].ack;
      step(vq[i].n);
      check($sformatf("row%0d", i), vq[i].st, vq[i].pins, vq[i].flg);
    end

    // asynchronous reset in the middle of SW_ON
    req_valid_i = 1'b0;
    #2 rst_ni = 1'b0;
    #1 check("async_rst", S_INIT, 5'b00001, 4'b0010);
    step(2);
    rst_ni = 1'b1;
    step(3);
    check("reboot_init", S_INIT, 5'b00001, 4'b0010);
    step(1);
    check("reboot_isorel", S_ISO_REL, 5'b01101, 4'b0010);
    step(1);
    check("reboot_on", S_ON, 5'b01101, 4'b1000);
    step(1);
    check("reboot_idle", S_ON, 5'b01101, 4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/ext_domain_pwr_seq.md
Name: ext_domain_pwr_seq

Overview:
- Sequences power-gating of one external (NTT/INTT) power domain attached to the MCU's external-subsystem power controls.
- Orders the domain's clock, isolation, reset and power-switch lines, and waits for the switch-cell acknowledge under a timeout.
- Sits between the system's software-visible power request and the domain's switch/iso/reset/clock-gate pins, so software issues one request instead of toggling pins.

Parameters:
- SYNC_STAGES, 2: flops in the ack synchroniser (≥2).
- ACK_TIMEOUT, 64: cycles allowed for switch ack before error (≥2).
- RST_CYCLES, 4: cycles domain reset is held after power-up (≥1).
- ISO_CYCLES, 2: settle cycles between isolation and the adjacent reset step (≥1).
- CNT_W, 8: counter width; must hold max(ACK_TIMEOUT, RST_CYCLES, ISO_CYCLES).

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: reset, asynchronous, active-low.
- req_valid_i, in, 1: power request valid.
- req_on_i, in, 1: request direction, 1 = power on, 0 = power off.
- req_ready_o, out, 1: request accepted when valid & ready.
- ret_en_i, in, 1: assert RAM retention while the domain is OFF.
- err_clr_i, in, 1: clear error and retry the ack wait.
- done_o, out, 1: one-cycle pulse on reaching ON or OFF.
- busy_o, out, 1: high when not in ON/OFF/ERROR.
- err_o, out, 1: high in ERROR.
- pwr_state_o, out, 4: current FSM state encoding.
- switch_no, out, 1: power switch, 0 = on.
- switch_ack_ni, in, 1: switch ack, asynchronous, 0 = on.
- iso_no, out, 1: isolation, 0 = isolated.
- rst_no, out, 1: domain reset, 0 = asserted.
- clk_en_no, out, 1: clock, 0 = running, 1 = gated.
- ret_no, out, 1: retention, 0 = retentive.

Behaviour:
- All outputs are registered.
- Reset values: state INIT, switch_no=0, iso_no=0, rst_no=0, clk_en_no=0, ret_no=1, req_ready_o=0, done_o=0, err_o=0.
- Ack: switch_ack_ni passes through SYNC_STAGES flops, giving ack_s. Its reset value is 0.
- Counter cnt: loaded with 0 on every state entry, increments each cycle within the state.

FSM (state, action, exit condition):
- INIT: rst_no=0, iso_no=0. Leaves when cnt==RST_CYCLES-1 → ISO_REL.
- ON: all active (switch_no=0, clk_en_no=0, rst_no=1, iso_no=1); ready=1. off request → CLK_OFF.
- CLK_OFF: clk_en_no←1, one cycle → ISO_ON.
- ISO_ON: iso_no←0. cnt==ISO_CYCLES-1 → RST_ON.
- RST_ON: rst_no←0, one cycle → SW_OFF.
- SW_OFF: switch_no←1. ack_s==1 → OFF; cnt==ACK_TIMEOUT-1 → ERROR.
- OFF: ready=1. ret_no=~ret_en_i, registered. on request → SW_ON; ret_no←1 on the same edge.
- SW_ON: switch_no←0. ack_s==0 → CLK_ON; timeout → ERROR.
- CLK_ON: clk_en_no←0, rst still held. cnt==RST_CYCLES-1 → RST_REL.
- RST_REL: rst_no←1. cnt==ISO_CYCLES-1 → ISO_REL.
- ISO_REL: iso_no←1, one cycle → ON with done_o pulse. The INIT path does not pulse done_o.
- ERROR: outputs frozen; err_o=1. err_clr_i → re-enter the wait state it came from with cnt=0. A 1-bit dir register records which.

Request rules:
- A request matching the current state (on while ON, off while OFF) is accepted and only pulses done_o the next cycle.
- Requests while busy or in ERROR are not accepted (ready=0); the requester holds them.
- done_o pulses in the cycle after the ON/OFF state is entered.

Boundary conditions:
- Ack already at target on SW_OFF/SW_ON entry: transition after one cycle in the state (the registered check).
- Ack and timeout in the same cycle: ack wins.
- Ack glitch back after the transition: ignored outside wait states.
- rst_ni low mid-sequence: immediate return to INIT values; domain reset asserted.
- err_clr_i outside ERROR: ignored.

Decomposition:
- Package ext_domain_pwr_seq_pkg holds pwr_state_e (4-bit enum, explicit encodings INIT=0 … ERROR=11) and the PWR_STATE_W=4 constant.
- One sub-module, ext_domain_pwr_ack_sync: SYNC_STAGES-deep synchroniser with a reset value parameter.

Test Plan:
- Reset release with ack delayed 15 cycles → INIT 4 cycles (rst_no=0), then iso_no=1, state ON; done_o stays 0.
- Off request from ON, ack 15 cycles late → clk_en_no=1, then iso_no=0, 2 cycles later rst_no=0, then switch_no=1. Reaches OFF sync+15 cycles after switch_no rises; done_o pulses once.
- On request from OFF with ret_en_i=1 → ret_no 0 in OFF, back to 1 at accept. After ack: clk runs, rst held 4 cycles, iso released 2 cycles after rst.
- Ack never toggles in SW_OFF (ACK_TIMEOUT=64) → ERROR after 64 cycles, err_o=1, outputs frozen. Toggle ack, pulse err_clr_i → OFF, done_o=1.
- Off request while OFF, and any request while busy → done_o next cycle, no pin change; while busy req_ready_o=0 until ON/OFF.
- rst_ni pulsed low during SW_ON → outputs immediately at reset values, state INIT, sequence restarts.
